// File: rtl/claw_motion_pkg.sv
// Shared types and default geometry for the claw motion controller.
package claw_motion_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWING   = 2'd1,
    EXTEND  = 2'd2,
    RETRACT = 2'd3
  } claw_state_t;

  // Loot weight classes 0..3
  localparam int WEIGHT_W = 2;

  // Default geometry for a 640x480 playfield
  localparam int DEF_POS_W        = 11;
  localparam int DEF_PIVOT_X      = 280;
  localparam int DEF_PIVOT_Y      = 50;
  localparam int DEF_RADIUS_SHIFT = 5;
  localparam int DEF_MAX_ANGLE    = 90;
  localparam int DEF_SWING_STEP   = 4;
  localparam int DEF_EXTEND_STEP  = 4;
  localparam int DEF_LIN_SHIFT    = 3;
  localparam int DEF_LEN_W        = 9;
  localparam int DEF_MAX_LEN      = 255;
  localparam int DEF_X_MIN        = 0;
  localparam int DEF_X_MAX        = 639;
  localparam int DEF_Y_MAX        = 479;

endpackage

// File: rtl/claw_polar_lut.sv
// Combinational polar-to-cartesian table: dx = R*sin(mag), dy = R*cos(mag)
// for mag in 0..90 degrees (larger inputs clamp to 90). Sine is held in
// Q8 and scaled by R = 2**RADIUS_SHIFT with round-to-nearest.
module claw_polar_lut #(
  parameter int OUT_W        = 11,
  parameter int RADIUS_SHIFT = 5
) (
  input  logic [6:0]       mag_i,
  output logic [OUT_W-1:0] dx_o,
  output logic [OUT_W-1:0] dy_o
);

  localparam logic [8:0] SIN_Q8 [91] = '{
    9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
    9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
    9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
    9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
    9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
    9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  logic [6:0]  idx;
  logic [31:0] sin_t;
  logic [31:0] cos_t;

  // Table lookup and radius scaling; cos(a) reuses the sine table at 90-a
  always_comb begin
    idx   = (mag_i > 7'd90) ? 7'd90 : mag_i;
    sin_t = 32'(SIN_Q8[idx]);
    cos_t = 32'(SIN_Q8[7'd90 - idx]);
    dx_o  = OUT_W'(((sin_t << RADIUS_SHIFT) + 32'd128) >> 8);
    dy_o  = OUT_W'(((cos_t << RADIUS_SHIFT) + 32'd128) >> 8);
  end

endmodule

// File: rtl/claw_motion_ctrl.sv
// Gold Miner claw motion controller: swings the claw about a pivot, extends
// it along the frozen angle when fired, retracts on collision / boundary /
// max length, and drives the sprite top-left position. Motion advances on
// frame ticks (every FRAME_DIV startOfFrame pulses, frozen by pause).
// Optional build macro CLAW_BOOST_EN adds a boost input that doubles the
// retract step.
module claw_motion_ctrl
  import claw_motion_pkg::*;
#(
  parameter int POS_W        = DEF_POS_W,
  parameter int PIVOT_X      = DEF_PIVOT_X,
  parameter int PIVOT_Y      = DEF_PIVOT_Y,
  parameter int RADIUS_SHIFT = DEF_RADIUS_SHIFT,
  parameter int MAX_ANGLE    = DEF_MAX_ANGLE,
  parameter int SWING_STEP   = DEF_SWING_STEP,
  parameter int FRAME_DIV    = 1,
  parameter int EXTEND_STEP  = DEF_EXTEND_STEP,
  parameter int LIN_SHIFT    = DEF_LIN_SHIFT,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int X_MIN        = DEF_X_MIN,
  parameter int X_MAX        = DEF_X_MAX,
  parameter int Y_MAX        = DEF_Y_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    fire,
  input  logic                    claw_collision,
  input  logic [WEIGHT_W-1:0]     loot_weight,
  input  logic                    pause,
`ifdef CLAW_BOOST_EN
  input  logic                    boost,
`endif
  output logic signed [POS_W-1:0] topLeftX,
  output logic signed [POS_W-1:0] topLeftY,
  output logic signed [7:0]       angle,
  output logic                    claw_busy,
  output logic                    claw_returned,
  output logic                    loot_grabbed
);

  localparam int PW   = POS_W + LEN_W;
  localparam int R    = 1 << RADIUS_SHIFT;
  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [FC_W-1:0]      FC_LAST = FC_W'(FRAME_DIV - 1);
  localparam logic signed [8:0]    STEP9   = 9'(SWING_STEP);
  localparam logic signed [8:0]    MAXA9   = 9'(MAX_ANGLE);
  localparam logic [LEN_W-1:0]     LMAX    = LEN_W'(MAX_LEN);
  localparam logic signed [PW-1:0] PIVX    = PW'(PIVOT_X);
  localparam logic signed [PW-1:0] PIVY    = PW'(PIVOT_Y);
  localparam logic signed [PW-1:0] XMIN    = PW'(X_MIN);
  localparam logic signed [PW-1:0] XMAX    = PW'(X_MAX);
  localparam logic signed [PW-1:0] YMAX    = PW'(Y_MAX);

  // Radial offset d + (d*L >>> LIN_SHIFT), computed at full product width
  function automatic logic signed [PW-1:0] lin_off(input logic [POS_W-1:0] d,
                                                    input logic [LEN_W-1:0] l);
    logic signed [PW-1:0] de, le, prod;
    de   = $signed({{LEN_W{1'b0}}, d});
    le   = $signed({{POS_W{1'b0}}, l});
    prod = de * le;
    return de + (prod >>> LIN_SHIFT);
  endfunction

  // Retract speed: heavier loot is slower, never below 1; boost doubles it
  function automatic logic [LEN_W-1:0] retract_step(input logic [WEIGHT_W-1:0] w,
                                                     input logic bst);
    logic [LEN_W-1:0] s;
    s = LEN_W'(EXTEND_STEP >> w);
    if (s == '0) s = LEN_W'(1);
    if (bst) s = s[LEN_W-1] ? '1 : {s[LEN_W-2:0], 1'b0};
    return s;
  endfunction

  claw_state_t           state_q;
  logic signed [7:0]     angle_q;
  logic                  dir_q;      // 0 = increasing angle
  logic [LEN_W-1:0]      len_q;
  logic [FC_W-1:0]       fcnt_q;
  logic                  grabbed_q;
  logic [WEIGHT_W-1:0]   weight_q;
  logic                  busy_q;
  logic                  returned_q;
  logic                  lgrab_q;
  logic signed [POS_W-1:0] x_q;
  logic signed [POS_W-1:0] y_q;

  logic                  tick_d;
  logic                  boost_d;
  logic [6:0]            mag_d;
  logic [POS_W-1:0]      dx_d;
  logic [POS_W-1:0]      dy_d;
  logic signed [8:0]     swing_sum_d;
  logic [LEN_W:0]        len_sum_d;
  logic [LEN_W-1:0]      len_ext_d;
  logic [LEN_W-1:0]      step_d;
  logic signed [PW-1:0]  x_cur_d, y_cur_d, x_ext_d, y_ext_d;
  logic                  hit_limit_d;

`ifdef CLAW_BOOST_EN
  assign boost_d = boost;
`else
  assign boost_d = 1'b0;
`endif

  assign tick_d      = startOfFrame && !pause && (fcnt_q == FC_LAST);
  assign mag_d       = angle_q[7] ? 7'(-angle_q) : 7'(angle_q);
  assign swing_sum_d = {angle_q[7], angle_q} + (dir_q ? -STEP9 : STEP9);
  assign len_sum_d   = {1'b0, len_q} + (LEN_W + 1)'(EXTEND_STEP);
  assign len_ext_d   = len_sum_d[LEN_W] ? '1 : len_sum_d[LEN_W-1:0];
  assign step_d      = retract_step(grabbed_q ? weight_q : '0, boost_d);

  claw_polar_lut #(
    .OUT_W        (POS_W),
    .RADIUS_SHIFT (RADIUS_SHIFT)
  ) u_lut (
    .mag_i (mag_d),
    .dx_o  (dx_d),
    .dy_o  (dy_d)
  );

  // Position at the current length (for the outputs) and at the post-tick
  // length (for the extend limit check, so the limit acts on the same tick)
  always_comb begin
    x_cur_d     = angle_q[7] ? PIVX - lin_off(dx_d, len_q) : PIVX + lin_off(dx_d, len_q);
    y_cur_d     = PIVY + lin_off(dy_d, len_q);
    x_ext_d     = angle_q[7] ? PIVX - lin_off(dx_d, len_ext_d) : PIVX + lin_off(dx_d, len_ext_d);
    y_ext_d     = PIVY + lin_off(dy_d, len_ext_d);
    hit_limit_d = (len_ext_d >= LMAX) || (x_ext_d < XMIN) || (x_ext_d > XMAX) ||
                  (y_ext_d > YMAX);
  end

  // Frame divider: counts unpaused startOfFrame pulses, wraps on the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (startOfFrame && !pause) begin
      fcnt_q <= (fcnt_q == FC_LAST) ? '0 : fcnt_q + FC_W'(1);
    end
  end

  // Claw state machine with angle, length and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      angle_q    <= '0;
      dir_q      <= 1'b0;
      len_q      <= '0;
      grabbed_q  <= 1'b0;
      weight_q   <= '0;
      busy_q     <= 1'b0;
      returned_q <= 1'b0;
      lgrab_q    <= 1'b0;
    end else begin
      returned_q <= 1'b0;
      lgrab_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startOfFrame) state_q <= SWING;
        end
        SWING: begin
          if (fire) begin
            state_q <= EXTEND;
            len_q   <= '0;
            busy_q  <= 1'b1;
          end else if (tick_d) begin
            if (swing_sum_d > MAXA9) begin
              angle_q <= 8'(MAXA9);
              dir_q   <= 1'b1;
            end else if (swing_sum_d < -MAXA9) begin
              angle_q <= 8'(-MAXA9);
              dir_q   <= 1'b0;
            end else begin
              angle_q <= 8'(swing_sum_d);
            end
          end
        end
        EXTEND: begin
          if (claw_collision) begin
            weight_q  <= loot_weight;
            grabbed_q <= 1'b1;
            state_q   <= RETRACT;
          end else if (tick_d) begin
            len_q <= len_ext_d;
            if (hit_limit_d) begin
              grabbed_q <= 1'b0;
              weight_q  <= '0;
              state_q   <= RETRACT;
            end
          end
        end
        RETRACT: begin
          if (tick_d) begin
            if (len_q <= step_d) begin
              len_q      <= '0;
              returned_q <= 1'b1;
              lgrab_q    <= grabbed_q;
              grabbed_q  <= 1'b0;
              weight_q   <= '0;
              busy_q     <= 1'b0;
              state_q    <= SWING;
            end else begin
              len_q <= len_q - step_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered sprite position, one cycle behind angle/length
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= POS_W'(PIVOT_X);
      y_q <= POS_W'(PIVOT_Y + R);
    end else begin
      x_q <= POS_W'(x_cur_d);
      y_q <= POS_W'(y_cur_d);
    end
  end

  assign topLeftX      = x_q;
  assign topLeftY      = y_q;
  assign angle         = angle_q;
  assign claw_busy     = busy_q;
  assign claw_returned = returned_q;
  assign loot_grabbed  = lgrab_q;

endmodule

// File: tb/tb_claw_motion_ctrl.sv
// Directed bench for claw_motion_ctrl: a step table covering swing, extend,
// retract, pause and reset, plus hand sequences for the return pulse, a
// FRAME_DIV=2 instance and (when CLAW_BOOST_EN is defined) the boost path.
module tb_claw_motion_ctrl;
  import claw_motion_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic fire = 1'b0;
  logic claw_collision = 1'b0;
  logic [1:0] loot_weight = 2'd0;
  logic pause = 1'b0;
  logic zero = 1'b0;
`ifdef CLAW_BOOST_EN
  logic boost = 1'b0;
`endif

  logic signed [10:0] topLeftX, topLeftY, x2, y2;
  logic signed [7:0]  angle, angle2;
  logic claw_busy, claw_returned, loot_grabbed, busy2, ret2, grab2;

  always #5 clk = ~clk;

  claw_motion_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fire(fire),
    .claw_collision(claw_collision), .loot_weight(loot_weight), .pause(pause),
`ifdef CLAW_BOOST_EN
    .boost(boost),
`endif
    .topLeftX(topLeftX), .topLeftY(topLeftY), .angle(angle),
    .claw_busy(claw_busy), .claw_returned(claw_returned), .loot_grabbed(loot_grabbed)
  );

  claw_motion_ctrl #(.FRAME_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fire(zero),
    .claw_collision(zero), .loot_weight(2'd0), .pause(pause),
`ifdef CLAW_BOOST_EN
    .boost(zero),
`endif
    .topLeftX(x2), .topLeftY(y2), .angle(angle2),
    .claw_busy(busy2), .claw_returned(ret2), .loot_grabbed(grab2)
  );

  typedef struct {
    bit          rst;
    bit          fire;
    bit          coll;
    logic [1:0]  wt;
    bit          pz;
    int          frames;
    claw_state_t st;
    int          ang;
    int          x;
    int          y;
    bit          busy;
  } vec_t;

  vec_t tv[16];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (tv[i].rst) begin
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
      end
      if (tv[i].fire) begin
        @(negedge clk) fire = 1'b1;
        @(negedge clk) fire = 1'b0;
      end
      if (tv[i].coll) begin
        @(negedge clk) begin claw_collision = 1'b1; loot_weight = tv[i].wt; end
        @(negedge clk) claw_collision = 1'b0;
      end
      pause = tv[i].pz;
      repeat (tv[i].frames) frame();
      pause = 1'b0;
      chk($sformatf("row%0d.state", i), int'(dut.state_q), int'(tv[i].st));
      chk($sformatf("row%0d.angle", i), int'(angle), tv[i].ang);
      chk($sformatf("row%0d.x", i), int'(topLeftX), tv[i].x);
      chk($sformatf("row%0d.y", i), int'(topLeftY), tv[i].y);
      chk($sformatf("row%0d.busy", i), int'(claw_busy), int'(tv[i].busy));
    end
  endtask

  task automatic check_return(input int exp_grab);
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    chk("ret.pulse", int'(claw_returned), 1);
    chk("ret.grabbed", int'(loot_grabbed), exp_grab);
    @(negedge clk);
    chk("ret.pulse_end", int'(claw_returned), 0);
    chk("ret.state", int'(dut.state_q), int'(SWING));
    chk("ret.busy", int'(claw_busy), 0);
    chk("ret.y", int'(topLeftY), 82);
  endtask

  initial begin
    //          rst fire coll wt  pz frm state    ang  x    y    busy
    tv[0]  = '{1, 0, 0, 2'd0, 0, 1,  SWING,   0,   280, 82,  0};
    tv[1]  = '{0, 0, 0, 2'd0, 0, 3,  SWING,   12,  287, 81,  0};
    tv[2]  = '{0, 0, 0, 2'd0, 0, 19, SWING,   88,  312, 51,  0};
    tv[3]  = '{0, 0, 0, 2'd0, 0, 1,  SWING,   90,  312, 50,  0};
    tv[4]  = '{0, 0, 0, 2'd0, 0, 1,  SWING,   86,  312, 52,  0};
    tv[5]  = '{1, 0, 0, 2'd0, 0, 1,  SWING,   0,   280, 82,  0};
    tv[6]  = '{0, 1, 0, 2'd0, 0, 3,  EXTEND,  0,   280, 130, 1};
    tv[7]  = '{0, 0, 1, 2'd2, 0, 11, RETRACT, 0,   280, 86,  1};
    tv[8]  = '{0, 1, 0, 2'd0, 0, 24, EXTEND,  0,   280, 466, 1};
    tv[9]  = '{0, 0, 0, 2'd0, 0, 1,  RETRACT, 0,   280, 482, 1};
    tv[10] = '{0, 0, 0, 2'd0, 0, 24, RETRACT, 0,   280, 98,  1};
    tv[11] = '{1, 0, 0, 2'd0, 0, 1,  SWING,   0,   280, 82,  0};
    tv[12] = '{0, 1, 0, 2'd0, 0, 2,  EXTEND,  0,   280, 114, 1};
    tv[13] = '{0, 0, 0, 2'd0, 1, 10, EXTEND,  0,   280, 114, 1};
    tv[14] = '{0, 0, 1, 2'd0, 0, 1,  RETRACT, 0,   280, 98,  1};
    tv[15] = '{1, 0, 0, 2'd0, 0, 0,  IDLE,    0,   280, 82,  0};

    // Reset state of both instances
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst.state", int'(dut.state_q), int'(IDLE));
    chk("rst.x", int'(topLeftX), 280);
    chk("rst.y", int'(topLeftY), 82);
    chk("rst.angle", int'(angle), 0);
    chk("rst.busy", int'(claw_busy), 0);
    chk("rst.returned", int'(claw_returned), 0);
    chk("rst.grabbed", int'(loot_grabbed), 0);
    chk("rst2.x", int'(x2), 280);
    chk("rst2.y", int'(y2), 82);
    chk("rst2.flags", int'({busy2, ret2, grab2}), 0);

    // FRAME_DIV=2 instance advances on every second startOfFrame
    repeat (3) frame();
    chk("div1.angle_3sof", int'(angle), 8);
    chk("div2.angle_3sof", int'(angle2), 4);
    frame();
    chk("div1.angle_4sof", int'(angle), 12);
    chk("div2.angle_4sof", int'(angle2), 8);

    apply_rows(0, 7);
    check_return(1);
    apply_rows(8, 10);
    check_return(0);
    apply_rows(11, 15);
    chk("midreset.returned", int'(claw_returned), 0);

`ifdef CLAW_BOOST_EN
    // Weight 1 gives step 2; boost doubles it to 4
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    frame();
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    repeat (3) frame();
    chk("boost.y_ext", int'(topLeftY), 130);
    @(negedge clk) begin claw_collision = 1'b1; loot_weight = 2'd1; boost = 1'b1; end
    @(negedge clk) claw_collision = 1'b0;
    frame();
    chk("boost.y_ret", int'(topLeftY), 114);
    boost = 1'b0;
    frame();
    chk("noboost.y_ret", int'(topLeftY), 106);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
